// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational ALU between two valid/ready
// requesters. The winner's operands are registered and driven to the ALU.
// MUL/DIV selects wait MULDIV_WAIT extra cycles before the result is captured.
// The response is held on a shared port until the consumer accepts it.
//
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, req0 wins contention ('last' still tracked)
//   undefined -> round-robin on the last granted requester
//
// state | meaning
// IDLE  | waiting for a request; the only state that grants
// EXEC  | operands on the ALU; wait counter runs down to zero
// RESP  | result held on the response port until resp_ready
module alu_req_arbiter #(
  parameter int unsigned MULDIV_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [3:0]  req1_sel,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_zf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_zf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] SEL_MUL = 4'b0010;
  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_NOP = 4'b0111;

  // Counter is 4 bits, so only 0..15 extra cycles are representable.
  localparam logic [3:0] WAIT_LD = 4'(MULDIV_WAIT);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_x_q, op_x_d;
  logic [31:0] op_y_q, op_y_d;
  logic [3:0]  op_sel_q, op_sel_d;
  logic        op_id_q, op_id_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_zf_q, resp_zf_d;

  logic        grant0, grant1;
  logic [31:0] win_x, win_y;
  logic [3:0]  win_sel;

  // Grant decision: only in IDLE, combinational from the valids.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        // last_q==1 means req1 went last, so req0 takes this one.
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_x   = grant1 ? req1_x   : req0_x;
    win_y   = grant1 ? req1_y   : req0_y;
    win_sel = grant1 ? req1_sel : req0_sel;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    op_sel_d    = op_sel_q;
    op_id_d     = op_id_q;
    resp_data_d = resp_data_q;
    resp_zf_d   = resp_zf_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          op_x_d   = win_x;
          op_y_d   = win_y;
          op_sel_d = win_sel;
          op_id_d  = grant1;
          last_d   = grant1;
          cnt_d    = (win_sel == SEL_MUL || win_sel == SEL_DIV) ? WAIT_LD : 4'd0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_data_d = alu_res;
          resp_zf_d   = alu_zf;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 4'd0;
      op_x_q      <= 32'd0;
      op_y_q      <= 32'd0;
      op_sel_q    <= SEL_NOP;
      op_id_q     <= 1'b0;
      resp_data_q <= 32'd0;
      resp_zf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      op_sel_q    <= op_sel_d;
      op_id_q     <= op_id_d;
      resp_data_q <= resp_data_d;
      resp_zf_q   <= resp_zf_d;
    end
  end

  // ALU sees the operand registers only in EXEC, a NOP otherwise.
  always_comb begin
    if (state_q == ST_EXEC) begin
      alu_x   = op_x_q;
      alu_y   = op_y_q;
      alu_sel = op_sel_q;
    end else begin
      alu_x   = 32'd0;
      alu_y   = 32'd0;
      alu_sel = SEL_NOP;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = op_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zf    = resp_zf_q;

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares the single combinational ALU between two requesters (req0 = main execute stage, req1 = auxiliary unit such as branch-compare/address-gen) using valid/ready handshakes. Arbitrates, registers operands into the ALU, waits a configurable number of extra cycles for multiply/divide selects, then captures result and zero flag and returns them with the requester ID on a shared response port held until accepted.

## Interface
Parameters:
- MULDIV_WAIT, 3, extra EXEC cycles for sel 4'b0010 (MUL) and 4'b0011 (DIV); legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_x, req0_y  in  32  requester 0 operands.
- req0_sel  in  4  requester 0 ALU select code.
- req1_valid / req1_ready / req1_x / req1_y / req1_sel: same for requester 1.
- alu_x, alu_y  out  32  operands driven to ALU.
- alu_sel  out  4  select driven to ALU.
- alu_res  in  32  ALU result.
- alu_zf  in  1  ALU zero flag.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer accepts.
- resp_id  out  1  requester that issued the response.
- resp_data  out  32  captured result.
- resp_zf  out  1  captured zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any reqN_valid, grant one; reqN_ready = (state==IDLE) & grantN (combinational from valid). On handshake: latch x, y, sel, id into operand registers; load wait counter with MULDIV_WAIT if sel is 0010/0011, else 0; go EXEC.
- Arbitration: round-robin. Pointer `last` holds ID of last grant; reset value 1 (req0 wins first contention). Both valid → grant !last. Single valid → grant it. `last` updates only on handshake.
- EXEC: alu_x/alu_y/alu_sel driven from operand registers. Counter nonzero → decrement, stay. Counter zero → capture alu_res/alu_zf into resp_data/resp_zf, go RESP.
- RESP: resp_valid=1; resp_id/data/zf stable. resp_valid & resp_ready → IDLE. No new request accepted before IDLE.
- Outside EXEC: alu_x = alu_y = 0, alu_sel = 4'b0111 (NOP).
- Undefined sel codes pass through unchanged; ALU returns 0, zf captured as 1.
- Requester inputs must remain stable while valid and not ready; not checked.
- Reset (any state, including mid-EXEC/RESP): immediately IDLE, in-flight op discarded, no response.

## Timing
- Reset values: req0_ready=0, req1_ready=0 (until valid seen in IDLE), resp_valid=0, resp_id=0, resp_data=0, resp_zf=0, alu_x=0, alu_y=0, alu_sel=4'b0111, last=1, counter=0.
- Handshake in cycle C → EXEC cycles C+1..C+1+W (W=0 or MULDIV_WAIT) → resp_valid first high in cycle C+2+W.
- Simple op: resp_valid in C+2; MUL/DIV with MULDIV_WAIT=3: C+5.
- Response accepted in cycle R → IDLE in R+1; earliest next reqN_ready in R+1.
- Peak throughput one op per 3+W cycles.
- resp_ready low: response held indefinitely, all outputs stable.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, req0 always wins when both valid; `last` still tracked but ignored for grant.
- Undefined (default): round-robin as in Operation.

## Test plan
- req0 x=5, y=7, sel=0000, resp_ready=1 → resp_valid in C+2, resp_id=0, resp_data=12, resp_zf=0; alu_sel=0111 again in C+3.
- req1 x=9, y=9, sel=0001 → resp_data=0, resp_zf=1, resp_id=1.
- Both valid continuously with AND ops after reset → grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN → grants 0,0,0.
- req0 sel=0010 x=6 y=7, MULDIV_WAIT=3 → EXEC 4 cycles, resp_valid in C+5, resp_data=42.
- resp_ready held low 10 cycles after resp_valid → resp fields stable, req0_ready/req1_ready stay 0; release → IDLE next cycle.
- rst asserted during EXEC of a DIV → next cycle all outputs at reset values, no response issued; next request serviced normally with req0 priority.
